// File: rtl/counter_chk_pkg.sv
// Shared types and default widths for the interconnect test counter generator/checker pair.
package counter_chk_pkg;

    localparam int unsigned CHK_DATA_W_DEF    = 8;
    localparam int unsigned CHK_STEP_DEF      = 1;
    localparam int unsigned CHK_MAX_VAL_DEF   = 255;
    localparam int unsigned CHK_SYNC_LEN_DEF  = 4;
    localparam int unsigned CHK_LOSS_LEN_DEF  = 4;
    localparam int unsigned CHK_ERR_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        CHK_HUNT,
        CHK_SYNC,
        CHK_LOCKED
    } chk_state_t;

    // Bits needed to count from 0 up to len inclusive.
    function automatic int unsigned chk_cnt_w(input int unsigned len);
        return (len < 2) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/counter_step_predictor.sv
// Combinational next-word model of the step-STEP up/down wrap counter generator.
module counter_step_predictor #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned STEP     = 1,
    parameter int unsigned DIR_DOWN = 0,
    parameter int unsigned MAX_VAL  = 255
) (
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] nxt_c
);

    localparam int unsigned EXT_W = DATA_W + 1;

    logic [EXT_W-1:0] cur_ext;
    logic [EXT_W-1:0] sum_ext;
    logic [EXT_W-1:0] dif_ext;

    // One extra bit keeps v+STEP from wrapping before the bound compare.
    always_comb begin
        cur_ext = {1'b0, cur};
        sum_ext = cur_ext + EXT_W'(STEP);
        dif_ext = cur_ext - EXT_W'(STEP);
        nxt_c   = '0;
        if (DIR_DOWN == 0) begin
            if (sum_ext > EXT_W'(MAX_VAL)) begin
                nxt_c = '0;
            end else begin
                nxt_c = sum_ext[DATA_W-1:0];
            end
        end else begin
            if (cur_ext < EXT_W'(STEP)) begin
                nxt_c = DATA_W'(MAX_VAL);
            end else begin
                nxt_c = dif_ext[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/counter_pattern_checker.sv
// Receive-side lock/predict/count checker for the interconnect test counter stream.
// Optional first-error capture ports are enabled by defining CHK_FIRST_ERR_EN.
module counter_pattern_checker
    import counter_chk_pkg::*;
#(
    parameter int unsigned DATA_W    = CHK_DATA_W_DEF,
    parameter int unsigned STEP      = CHK_STEP_DEF,
    parameter int unsigned DIR_DOWN  = 0,
    parameter int unsigned MAX_VAL   = CHK_MAX_VAL_DEF,
    parameter int unsigned SYNC_LEN  = CHK_SYNC_LEN_DEF,
    parameter int unsigned LOSS_LEN  = CHK_LOSS_LEN_DEF,
    parameter int unsigned ERR_CNT_W = CHK_ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lost_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [DATA_W-1:0]    exp_data
`ifdef CHK_FIRST_ERR_EN
    ,
    output logic                 first_err_vld,
    output logic [DATA_W-1:0]    first_err_exp,
    output logic [DATA_W-1:0]    first_err_got
`endif
);

    localparam int unsigned MATCH_W = chk_cnt_w(SYNC_LEN);
    localparam int unsigned MISS_W  = chk_cnt_w(LOSS_LEN);

    chk_state_t           state_q, state_d;
    logic [DATA_W-1:0]    exp_q, exp_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 lost_pulse_q, lost_pulse_d;
    logic                 err_hit_c;
    logic                 match_c;
    logic [DATA_W-1:0]    nxt_in_c;
    logic [DATA_W-1:0]    nxt_exp_c;

    counter_step_predictor #(
        .DATA_W   (DATA_W),
        .STEP     (STEP),
        .DIR_DOWN (DIR_DOWN),
        .MAX_VAL  (MAX_VAL)
    ) u_pred_in (
        .cur   (in_data),
        .nxt_c (nxt_in_c)
    );

    counter_step_predictor #(
        .DATA_W   (DATA_W),
        .STEP     (STEP),
        .DIR_DOWN (DIR_DOWN),
        .MAX_VAL  (MAX_VAL)
    ) u_pred_exp (
        .cur   (exp_q),
        .nxt_c (nxt_exp_c)
    );

    assign match_c = (in_data == exp_q);

    // Lock FSM; while locked the predictor runs from the expected word, never the received one.
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        match_d      = match_q;
        miss_d       = miss_q;
        err_pulse_d  = 1'b0;
        lost_pulse_d = 1'b0;
        err_hit_c    = 1'b0;
        if (in_valid) begin
            case (state_q)
                CHK_HUNT: begin
                    exp_d   = nxt_in_c;
                    match_d = '0;
                    miss_d  = '0;
                    state_d = CHK_SYNC;
                end
                CHK_SYNC: begin
                    if (match_c) begin
                        exp_d = nxt_exp_c;
                        if (match_q == MATCH_W'(SYNC_LEN - 1)) begin
                            match_d = '0;
                            miss_d  = '0;
                            state_d = CHK_LOCKED;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        exp_d   = nxt_in_c;
                        match_d = '0;
                    end
                end
                CHK_LOCKED: begin
                    exp_d = nxt_exp_c;
                    if (match_c) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_hit_c   = 1'b1;
                        if (miss_q == MISS_W'(LOSS_LEN - 1)) begin
                            miss_d       = '0;
                            lost_pulse_d = 1'b1;
                            state_d      = CHK_HUNT;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = CHK_HUNT;
                end
            endcase
        end
        locked_d = (state_d == CHK_LOCKED);
    end

    // Clear takes effect before the same-beat increment.
    always_comb begin
        err_count_d = clear ? '0 : err_count_q;
        if (err_hit_c && (err_count_d != '1)) begin
            err_count_d = err_count_d + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CHK_HUNT;
            exp_q        <= '0;
            match_q      <= '0;
            miss_q       <= '0;
            err_count_q  <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            lost_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            err_count_q  <= err_count_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            lost_pulse_q <= lost_pulse_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign lost_pulse = lost_pulse_q;
    assign err_count  = err_count_q;
    assign exp_data   = exp_q;

`ifdef CHK_FIRST_ERR_EN
    logic              first_vld_q, first_vld_d;
    logic [DATA_W-1:0] first_exp_q, first_exp_d;
    logic [DATA_W-1:0] first_got_q, first_got_d;

    // Holds the first locked mismatch since reset or clear.
    always_comb begin
        first_vld_d = clear ? 1'b0 : first_vld_q;
        first_exp_d = clear ? '0   : first_exp_q;
        first_got_d = clear ? '0   : first_got_q;
        if (err_hit_c && !first_vld_d) begin
            first_vld_d = 1'b1;
            first_exp_d = exp_q;
            first_got_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_vld_q <= 1'b0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            first_vld_q <= first_vld_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign first_err_vld = first_vld_q;
    assign first_err_exp = first_exp_q;
    assign first_err_got = first_got_q;
`endif

endmodule

// File: tb/tb_counter_pattern_checker.sv
// Directed self-checking bench for counter_pattern_checker (default and CHK_FIRST_ERR_EN builds).
module tb_counter_pattern_checker;

    logic       clk;
    logic       rst_n;
    logic       clear      [4];
    logic       in_valid   [4];
    logic [7:0] in_data    [4];
    logic       locked     [4];
    logic       err_pulse  [4];
    logic       lost_pulse [4];
    logic [7:0] exp_data   [4];
    logic [15:0] err_cnt   [3];
    logic [3:0]  err_cnt_sat;
`ifdef CHK_FIRST_ERR_EN
    logic       fe_vld [4];
    logic [7:0] fe_exp [4];
    logic [7:0] fe_got [4];
`endif

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // idx 0: STEP=1 up
    counter_pattern_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .locked(locked[0]), .err_pulse(err_pulse[0]), .lost_pulse(lost_pulse[0]),
        .err_count(err_cnt[0]), .exp_data(exp_data[0])
`ifdef CHK_FIRST_ERR_EN
        , .first_err_vld(fe_vld[0]), .first_err_exp(fe_exp[0]), .first_err_got(fe_got[0])
`endif
    );

    // idx 1: STEP=3 up
    counter_pattern_checker #(.STEP(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .locked(locked[1]), .err_pulse(err_pulse[1]), .lost_pulse(lost_pulse[1]),
        .err_count(err_cnt[1]), .exp_data(exp_data[1])
`ifdef CHK_FIRST_ERR_EN
        , .first_err_vld(fe_vld[1]), .first_err_exp(fe_exp[1]), .first_err_got(fe_got[1])
`endif
    );

    // idx 2: STEP=3 down
    counter_pattern_checker #(.STEP(3), .DIR_DOWN(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .locked(locked[2]), .err_pulse(err_pulse[2]), .lost_pulse(lost_pulse[2]),
        .err_count(err_cnt[2]), .exp_data(exp_data[2])
`ifdef CHK_FIRST_ERR_EN
        , .first_err_vld(fe_vld[2]), .first_err_exp(fe_exp[2]), .first_err_got(fe_got[2])
`endif
    );

    // idx 3: 4-bit saturating counter, loss effectively disabled
    counter_pattern_checker #(.ERR_CNT_W(4), .LOSS_LEN(255)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clear[3]), .in_valid(in_valid[3]), .in_data(in_data[3]),
        .locked(locked[3]), .err_pulse(err_pulse[3]), .lost_pulse(lost_pulse[3]),
        .err_count(err_cnt_sat), .exp_data(exp_data[3])
`ifdef CHK_FIRST_ERR_EN
        , .first_err_vld(fe_vld[3]), .first_err_exp(fe_exp[3]), .first_err_got(fe_got[3])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One cycle on lane idx; outputs are sampled 1 time unit after the capturing edge.
    task automatic tick(input int idx, input logic v, input logic [7:0] d, input logic clr);
        in_valid[idx] = v;
        in_data[idx]  = d;
        clear[idx]    = clr;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        clear[idx]    = 1'b0;
    endtask

    int errs;
    int losts;
    int bad;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        for (int i = 0; i < 4; i++) begin
            clear[i]    = 1'b0;
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked[0]), 0);
        check("rst_pulses", 32'({err_pulse[0], lost_pulse[0]}), 0);
        check("rst_err_count", 32'(err_cnt[0]), 0);
        check("rst_exp_data", 32'(exp_data[0]), 0);
        rst_n = 1'b1;

        // Lock on a continuous STEP=1 stream and run across the wrap.
        for (int v = 0; v < 5; v++) begin
            tick(0, 1'b1, 8'(v), 1'b0);
            if (v == 3) check("lock_not_yet", 32'(locked[0]), 0);
        end
        check("lock_after_5th", 32'(locked[0]), 1);
        check("lock_exp_data", 32'(exp_data[0]), 5);
        errs = 0;
        for (int v = 5; v < 256 + 10; v++) begin
            tick(0, 1'b1, 8'(v), 1'b0);
            errs += int'(err_pulse[0]);
        end
        check("wrap_err_pulses", 32'(errs), 0);
        check("wrap_err_count", 32'(err_cnt[0]), 0);
        check("wrap_locked", 32'(locked[0]), 1);
        check("wrap_exp_data", 32'(exp_data[0]), 10);

        // Single corrupted word.
        tick(0, 1'b1, 8'd10, 1'b0);
        tick(0, 1'b1, 8'd11, 1'b0);
        tick(0, 1'b1, 8'd12, 1'b0);
        tick(0, 1'b1, 8'h5D, 1'b0);
        check("corrupt_err_pulse", 32'(err_pulse[0]), 1);
        check("corrupt_err_count", 32'(err_cnt[0]), 1);
        check("corrupt_exp_next", 32'(exp_data[0]), 14);
        tick(0, 1'b1, 8'd14, 1'b0);
        check("corrupt_resume_pulse", 32'(err_pulse[0]), 0);
        check("corrupt_resume_count", 32'(err_cnt[0]), 1);
        check("corrupt_still_locked", 32'(locked[0]), 1);
`ifdef CHK_FIRST_ERR_EN
        check("first_err_vld", 32'(fe_vld[0]), 1);
        check("first_err_exp", 32'(fe_exp[0]), 13);
        check("first_err_got", 32'(fe_got[0]), 32'h5D);
`endif
        tick(0, 1'b1, 8'd15, 1'b0);

        // Dropped word: 4 consecutive mismatches lose lock.
        tick(0, 1'b1, 8'd16, 1'b1);
        check("clear_err_count", 32'(err_cnt[0]), 0);
`ifdef CHK_FIRST_ERR_EN
        check("clear_first_vld", 32'(fe_vld[0]), 0);
`endif
        for (int v = 17; v < 22; v++) tick(0, 1'b1, 8'(v), 1'b0);
        losts = 0;
        errs  = 0;
        for (int v = 23; v < 27; v++) begin
            tick(0, 1'b1, 8'(v), 1'b0);
            errs  += int'(err_pulse[0]);
            losts += int'(lost_pulse[0]);
            if (v == 25) check("drop_still_locked", 32'(locked[0]), 1);
        end
        check("drop_lost_pulse", 32'(lost_pulse[0]), 1);
        check("drop_locked", 32'(locked[0]), 0);
        check("drop_err_count", 32'(err_cnt[0]), 4);
        check("drop_err_pulses", 32'(errs), 4);
        for (int v = 27; v < 32; v++) begin
            tick(0, 1'b1, 8'(v), 1'b0);
            losts += int'(lost_pulse[0]);
            if (v == 30) check("relock_not_yet", 32'(locked[0]), 0);
        end
        check("relock_locked", 32'(locked[0]), 1);
        check("relock_lost_once", 32'(losts), 1);
        check("relock_err_count", 32'(err_cnt[0]), 4);

        // in_valid low mid-stream.
        for (int v = 32; v < 36; v++) tick(0, 1'b1, 8'(v), 1'b0);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick(0, 1'b0, 8'hFF, 1'b0);
            if (exp_data[0] !== 8'd36 || err_pulse[0] || lost_pulse[0] || !locked[0]) bad++;
        end
        check("gap_hold", 32'(bad), 0);
        errs = 0;
        for (int v = 36; v < 40; v++) begin
            tick(0, 1'b1, 8'(v), 1'b0);
            errs += int'(err_pulse[0]);
        end
        check("gap_resume_errs", 32'(errs), 0);
        check("gap_resume_count", 32'(err_cnt[0]), 4);
        check("gap_resume_exp", 32'(exp_data[0]), 40);

        // STEP=3 up wrap.
        for (int v = 240; v <= 252; v += 3) tick(1, 1'b1, 8'(v), 1'b0);
        check("s3_locked", 32'(locked[1]), 1);
        tick(1, 1'b1, 8'd255, 1'b0);
        check("s3_exp_after_255", 32'(exp_data[1]), 0);
        check("s3_no_err_255", 32'(err_pulse[1]), 0);
        tick(1, 1'b1, 8'd0, 1'b0);
        check("s3_exp_after_0", 32'(exp_data[1]), 3);
        tick(1, 1'b1, 8'd3, 1'b0);
        check("s3_err_count", 32'(err_cnt[1]), 0);
        check("s3_still_locked", 32'(locked[1]), 1);

        // STEP=3 down wrap.
        for (int v = 14; v >= 2; v -= 3) tick(2, 1'b1, 8'(v), 1'b0);
        check("dn_locked", 32'(locked[2]), 1);
        check("dn_exp_after_2", 32'(exp_data[2]), 255);
        tick(2, 1'b1, 8'd255, 1'b0);
        check("dn_exp_after_255", 32'(exp_data[2]), 252);
        check("dn_no_err", 32'(err_pulse[2]), 0);

        // Saturation, clear, async reset mid-lock.
        for (int v = 0; v < 5; v++) tick(3, 1'b1, 8'(v), 1'b0);
        check("sat_locked", 32'(locked[3]), 1);
        for (int i = 0; i < 20; i++) begin
            tick(3, 1'b1, 8'(5 + i) ^ 8'h80, 1'b0);
            if (i == 14) check("sat_count_15", 32'(err_cnt_sat), 15);
        end
        check("sat_count_held", 32'(err_cnt_sat), 15);
        check("sat_still_locked", 32'(locked[3]), 1);
        check("sat_exp_data", 32'(exp_data[3]), 25);
        tick(3, 1'b1, 8'd25, 1'b1);
        check("sat_clear", 32'(err_cnt_sat), 0);
        tick(3, 1'b1, 8'hAA, 1'b1);
        check("clear_with_err", 32'(err_cnt_sat), 1);
        check("clear_with_err_pulse", 32'(err_pulse[3]), 1);
        rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(locked[3]), 0);
        check("arst_outputs", 32'({err_pulse[3], lost_pulse[3], err_cnt_sat, exp_data[3]}), 0);
        check("arst_dut0_locked", 32'(locked[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 50; v < 55; v++) tick(0, 1'b1, 8'(v), 1'b0);
        check("arst_relock", 32'(locked[0]), 1);
        check("arst_relock_count", 32'(err_cnt[0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
